// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath.
// Each instruction is stepped through fetch, decode, execute, memory and
// writeback. Every state drives the datapath's mux selects, write enables
// and ALUControl.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | IR <= mem[PC], OldPC <= PC, PC <= PC+4
// DECODE   | ALUOut <= OldPC+Imm (branch/jal target), dispatch on opcode
// MEMADR   | ALUOut <= rs1+Imm (load/store address)
// MEMREAD  | Data <= mem[ALUOut]
// MEMWB    | rd <= Data
// MEMWRITE | mem[ALUOut] <= rs2
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op Imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
// JAL      | PC <= ALUOut (target), ALUOut <= OldPC+4
// JALRADR  | ALUOut <= rs1+Imm (jalr target)
// JALRPC   | PC <= ALUOut, ALUOut <= OldPC+4
// LUI      | rd <= ImmExt
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALRADR  = 4'd11,
    S_JALRPC   = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  state_t cur;
  state_t nxt;
  logic [2:0] alu_f3;

  assign state = cur;

  // ALU operation named by funct3 for register and immediate ALU ops
  always_comb begin
    case (funct3)
      3'b111:  alu_f3 = ALU_AND;
      3'b110:  alu_f3 = ALU_OR;
      3'b100:  alu_f3 = ALU_XOR;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      default: alu_f3 = ALU_ADD;
    endcase
  end

  // Next-state selection
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_RTYPE:          nxt = S_EXECR;
          OP_ITYPE:          nxt = S_EXECI;
          OP_BRANCH:         nxt = S_BRANCH;
          OP_JAL:            nxt = S_JAL;
          OP_JALR:           nxt = S_JALRADR;
          OP_LUI:            nxt = S_LUI;
          default:           nxt = S_FETCH;
        endcase
      end
      S_MEMADR:  nxt = (Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: nxt = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL,
      S_JALRPC:  nxt = S_ALUWB;
      S_JALRADR: nxt = S_JALRPC;
      default:   nxt = S_FETCH;
    endcase
  end

  // State register; reset abandons any partial instruction
  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (Opcode)
      OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = 3'b000;
      OP_STORE:                   ImmSrc = 3'b001;
      OP_BRANCH:                  ImmSrc = 3'b010;
      OP_JAL:                     ImmSrc = 3'b011;
      OP_LUI:                     ImmSrc = 3'b100;
      default:                    ImmSrc = 3'b000;
    endcase
  end

  // Moore outputs per state; write enables are masked while reset is held.
  // The branch PCWrite uses the current-cycle Zero flag of the comparison.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    case (cur)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR, S_JALRADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        if (funct3 == 3'b000)
          ALUControl = (funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
        else
          ALUControl = alu_f3;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_f3;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        case (funct3)
          3'b000: begin ALUControl = ALU_SUB; PCWrite = Zero;  end
          3'b001: begin ALUControl = ALU_SUB; PCWrite = ~Zero; end
          3'b100: begin ALUControl = ALU_SLT; PCWrite = ~Zero; end
          3'b101: begin ALUControl = ALU_SLT; PCWrite = Zero;  end
          default: PCWrite = 1'b0;
        endcase
      end
      S_JAL, S_JALRPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instructions, then random
// instruction streams with occasional mid-instruction reset, each checked
// against an instruction-level model of the control sequence.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .state(state)
  );

  always #5 clk = ~clk;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4,
                 C_JAL = 5, C_JALR = 6, C_LUI = 7, C_ILL = 8;

  // state trajectory of each instruction class, FETCH to next FETCH
  localparam int SEQ [9][5] = '{
    '{0, 1, 2, 3, 4},
    '{0, 1, 2, 5, 0},
    '{0, 1, 6, 8, 0},
    '{0, 1, 7, 8, 0},
    '{0, 1, 9, 0, 0},
    '{0, 1, 10, 8, 0},
    '{0, 1, 11, 12, 8},
    '{0, 1, 13, 0, 0},
    '{0, 1, 0, 0, 0}
  };
  localparam int LEN [9] = '{5, 4, 4, 4, 3, 4, 5, 3, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] opc_of(input int cls);
    case (cls)
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_BR:    return 7'b1100011;
      C_JAL:   return 7'b1101111;
      C_JALR:  return 7'b1100111;
      C_LUI:   return 7'b0110111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int imm_of(input int cls);
    case (cls)
      C_SW:    return 1;
      C_BR:    return 2;
      C_JAL:   return 3;
      C_LUI:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return !z;
      3'b101:  return z;
      default: return 1'b0;
    endcase
  endfunction

  // ALU op the instruction asks for during its execute step
  function automatic int alu_exp(input int cls, input logic [2:0] f3, input logic [6:0] f7);
    if (cls == C_BR) begin
      if (f3 == 3'b000 || f3 == 3'b001) return 1;
      if (f3 == 3'b100 || f3 == 3'b101) return 5;
      return 0;
    end
    case (f3)
      3'b000:  return (cls == C_R && f7 == 7'b0100000) ? 1 : 0;
      3'b111:  return 2;
      3'b110:  return 3;
      3'b100:  return 4;
      3'b010:  return 5;
      3'b011:  return 6;
      default: return 0;
    endcase
  endfunction

  // {PCWrite, IRWrite, MemWrite, RegWrite}: fetch writes PC+IR, the one
  // architectural write of the instruction lands at its last step (jumps
  // also load PC one step earlier), illegal opcodes write nothing.
  function automatic logic [3:0] en_exp(input int cls, input int s,
                                        input logic [2:0] f3, input logic z);
    if (s == 0) return 4'b1100;
    if (cls == C_JAL && s == 2) return 4'b1000;
    if (cls == C_JALR && s == 3) return 4'b1000;
    if (s == LEN[cls] - 1) begin
      case (cls)
        C_SW:    return 4'b0010;
        C_BR:    return taken(f3, z) ? 4'b1000 : 4'b0000;
        C_ILL:   return 4'b0000;
        default: return 4'b0001;
      endcase
    end
    return 4'b0000;
  endfunction

  // Runs one instruction starting at a negedge in FETCH; rst_step >= 0
  // raises reset at that step, holds it two edges and abandons the rest.
  task automatic run_instr(input int cls, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input int rst_step);
    for (int s = 0; s < LEN[cls]; s++) begin
      Opcode = opc;
      funct3 = f3;
      funct7 = f7;
      Zero   = z;
      rst    = (s == rst_step);
      #1;
      chk("state", state, SEQ[cls][s]);
      if (rst) begin
        chk("en_in_rst", {PCWrite, IRWrite, MemWrite, RegWrite}, 0);
        @(posedge clk); @(negedge clk); #1;
        chk("state_in_rst", state, 0);
        chk("en_in_rst2", {PCWrite, IRWrite, MemWrite, RegWrite}, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        return;
      end
      chk("enables", {PCWrite, IRWrite, MemWrite, RegWrite}, en_exp(cls, s, f3, z));
      chk("immsrc", ImmSrc, imm_of(cls));
      if (s == 0) begin
        chk("fetch_srcb", ALUSrcB, 2);
        chk("fetch_res", ResultSrc, 2);
        chk("fetch_adr", AdrSrc, 0);
        chk("fetch_alu", ALUControl, 0);
      end
      if (s == 1) begin
        chk("dec_srca", ALUSrcA, 1);
        chk("dec_srcb", ALUSrcB, 1);
        chk("dec_alu", ALUControl, 0);
      end
      if (s == 2 && (cls == C_R || cls == C_I || cls == C_BR))
        chk("exec_alu", ALUControl, alu_exp(cls, f3, f7));
      if (s == 2 && cls == C_R) chk("r_srcs", {ALUSrcA, ALUSrcB}, 4'b1000);
      if (s == 2 && cls == C_I) chk("i_srcs", {ALUSrcA, ALUSrcB}, 4'b1001);
      if (s == 3 && (cls == C_LW || cls == C_SW)) chk("mem_adr", AdrSrc, 1);
      if (s == 4 && cls == C_LW) chk("lw_res", ResultSrc, 1);
      if (s == 2 && cls == C_LUI) chk("lui_res", ResultSrc, 3);
      if (s == 3 && cls == C_JALR) chk("jalr_srcs", {ALUSrcA, ALUSrcB, ResultSrc}, 6'b011000);
      @(posedge clk); @(negedge clk);
    end
  endtask

  logic [2:0] f3_ok [6] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010, 3'b011};
  logic [6:0] ill_op [4] = '{7'b1111111, 7'b0000000, 7'b0010111, 7'b1110011};

  initial begin
    int cls, rs;
    logic [2:0] f3;
    logic [6:0] f7, opc;
    logic z;

    rst = 1'b1; Opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0; Zero = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    chk("reset_state", state, 0);
    chk("reset_en", {PCWrite, IRWrite, MemWrite, RegWrite}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_instr(C_R,    opc_of(C_R),    3'b000, 7'b0000000, 1'b0, -1);
    run_instr(C_R,    opc_of(C_R),    3'b000, 7'b0100000, 1'b0, -1);
    run_instr(C_I,    opc_of(C_I),    3'b000, 7'b0100000, 1'b0, -1);
    run_instr(C_LW,   opc_of(C_LW),   3'b010, 7'b0, 1'b0, -1);
    run_instr(C_SW,   opc_of(C_SW),   3'b010, 7'b0, 1'b0, -1);
    run_instr(C_BR,   opc_of(C_BR),   3'b000, 7'b0, 1'b1, -1);
    run_instr(C_BR,   opc_of(C_BR),   3'b001, 7'b0, 1'b1, -1);
    run_instr(C_BR,   opc_of(C_BR),   3'b101, 7'b0, 1'b0, -1);
    run_instr(C_JAL,  opc_of(C_JAL),  3'b000, 7'b0, 1'b0, -1);
    run_instr(C_JALR, opc_of(C_JALR), 3'b000, 7'b0, 1'b0, -1);
    run_instr(C_LUI,  opc_of(C_LUI),  3'b000, 7'b0, 1'b0, -1);
    run_instr(C_ILL,  7'b1111111,     3'b000, 7'b0, 1'b0, -1);
    run_instr(C_SW,   opc_of(C_SW),   3'b010, 7'b0, 1'b0, 2);
    run_instr(C_SW,   opc_of(C_SW),   3'b010, 7'b0, 1'b0, -1);

    for (int n = 0; n < 400; n++) begin
      cls = $urandom_range(0, 8);
      f3  = 3'($urandom_range(0, 7));
      f7  = 7'($urandom);
      z   = 1'($urandom);
      if (cls == C_R || cls == C_I) f3 = f3_ok[$urandom_range(0, 5)];
      if (cls == C_R) f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
      opc = (cls == C_ILL) ? ill_op[$urandom_range(0, 3)] : opc_of(cls);
      rs  = ($urandom_range(0, 19) == 0) ? $urandom_range(1, LEN[cls] - 1) : -1;
      run_instr(cls, opc, f3, f7, z, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
